latch_bank_ctrl: RTL
====================

// Module: latch_bank_ctrl
// PURPOSE
//  Clocked sequencer that shares one bank of level-sensitive D latches (d_latch: En, D -> Q)
//  between two write requesters.
//  Round-robin arbitration picks a requester; the controller then drives the shared data bus
//  and one latch enable in a fixed SETUP / ENABLE / HOLD sequence.
//  D is always stable before En rises and until after En falls.
//  Sits between synchronous logic and the asynchronous latch bank.
// PARAMETERS
//  WIDTH       8  data bits per latch word (width of lat_d)
//  ADDR_W      2  latch select bits; bank holds N_LATCH = 1<<ADDR_W words
//  EN_CYCLES   2  cycles lat_en is held high per write (>=1)
//  HOLD_CYCLES 1  cycles lat_d is held after lat_en falls (>=1)
// PORTS
//  clk     in   1            single clock, all state updates on rising edge
//  rst     in   1            synchronous reset, active-high
//  req0    in   1            requester 0 write request, level, held until ack0
//  addr0   in   ADDR_W       requester 0 latch select
//  data0   in   WIDTH        requester 0 write data
//  req1    in   1            requester 1 write request, level, held until ack1
//  addr1   in   ADDR_W       requester 1 latch select
//  data1   in   WIDTH        requester 1 write data
//  gnt0    out  1            requester 0 owns the bank (capture through ACK)
//  gnt1    out  1            requester 1 owns the bank
//  ack0    out  1            one-cycle pulse: requester 0 write complete
//  ack1    out  1            one-cycle pulse: requester 1 write complete
//  lat_en  out  N_LATCH      one-hot latch enables (En of each d_latch)
//  lat_d   out  WIDTH        shared latch data bus (D of every d_latch)
//  busy    out  1            high whenever state != IDLE
// BEHAVIOUR
//  Reset:
//  - state=IDLE, all outputs 0 (gnt*, ack*, lat_en, lat_d, busy); rr pointer = 0 (req0 first).
//  - Reset in any state forces IDLE on the next edge: lat_en drops that edge, no ack is issued,
//    and the write is abandoned.
//  - Requester must re-request after reset.
//  FSM (all outputs registered):
//  - IDLE: if any req is high, choose a winner, capture its addr/data, set its gnt, go to SETUP.
//    Arbitration:
//    - Only one req high: that requester wins.
//    - Both high: the rr pointer picks the winner.
//  - SETUP: 1 cycle. lat_d = captured data, lat_en = 0.
//  - ENABLE: EN_CYCLES cycles. lat_en[addr] = 1 (exactly one bit), lat_d unchanged.
//  - HOLD: HOLD_CYCLES cycles. lat_en = 0, lat_d unchanged.
//  - ACK: 1 cycle. ack of the granted requester = 1, gnt still high. rr pointer = other
//    requester. Next state is IDLE with gnt cleared.
//  - lat_d keeps its last value in IDLE; it changes only on entry to SETUP.
//  - Latency with defaults: req seen at edge 0 -> SETUP at cycle 1, ENABLE cycles 2-3,
//    HOLD cycle 4, ack at cycle 5.
//    In general, ack arrives EN_CYCLES+HOLD_CYCLES+2 cycles after the capture edge.
//  - Captured addr/data are private copies: input changes after capture have no effect on the
//    write in progress.
//  - A req still high in the IDLE cycle after ACK is treated as a new request; the requester
//    must drop req on the ack cycle to avoid a duplicate write.
//    Sustained dual requests alternate 0,1,0,1.
//  - A req that rises while busy waits; it is sampled at the next IDLE.
//  - Never more than one lat_en bit high; gnt0 and gnt1 never both high; ack0 and ack1 never
//    both high.
//  - Counters are sized for max(EN_CYCLES, HOLD_CYCLES) and do not wrap mid-phase.
// TESTING
//  - Reset, then idle 5 cycles -> all outputs 0, busy=0.
//  - req0=1 with addr0=2, data0=8'hA5 -> gnt0 at cycle 1.
//    lat_d=A5 at cycle 1; lat_en=4'b0100 at cycles 2-3; lat_en=0 with lat_d=A5 at cycle 4;
//    ack0 pulse at cycle 5.
//  - req0 and req1 high together from reset, each dropped on its own ack -> writes are
//    serviced 0 then 1.
//    ack0 at cycle 5, ack1 at cycle 11; lat_en=0001 for addr0=0, then 1000 for addr1=3.
//  - Change data0 from A5 to 3C during ENABLE -> latched word stays A5, lat_d stays A5 until
//    the next SETUP.
//  - Assert rst during ENABLE -> lat_en=0 and state IDLE on the next edge, no ack0.
//    A following req0 completes normally.
//  - Hold req1 continuously with req0 low -> ack1 every 6 cycles.
//    Check lat_en never has two bits set and gnt0 never rises.

Source files
------------

// File: rtl/latch_bank_ctrl_if.sv
// Bundle between the two write requesters and the latch bank controller.
// master: requester side (drives req/addr/data, observes gnt/ack and the latch bus).
// slave:  controller side (drives gnt/ack, latch enables, latch data and busy).
interface latch_bank_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    localparam int N_LATCH = 1 << ADDR_W;

    logic               req0;
    logic [ADDR_W-1:0]  addr0;
    logic [WIDTH-1:0]   data0;
    logic               req1;
    logic [ADDR_W-1:0]  addr1;
    logic [WIDTH-1:0]   data1;
    logic               gnt0;
    logic               gnt1;
    logic               ack0;
    logic               ack1;
    logic [N_LATCH-1:0] lat_en;
    logic [WIDTH-1:0]   lat_d;
    logic               busy;

    modport master (
        output req0, addr0, data0, req1, addr1, data1,
        input  gnt0, gnt1, ack0, ack1, lat_en, lat_d, busy
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1,
        output gnt0, gnt1, ack0, ack1, lat_en, lat_d, busy
    );
endinterface

// File: rtl/latch_bank_ctrl.sv
// Round-robin sequencer sharing one bank of D latches between two write requesters.
// Latency: ack EN_CYCLES+HOLD_CYCLES+2 cycles after the capture edge (5 with defaults).
// Backpressure: a req is held until its ack; requests arriving while busy wait for IDLE.
// Ports: clk, rst (sync, active-high); bus (slave) carries req/addr/data per requester,
// gnt/ack per requester, one-hot lat_en, shared lat_d and busy. All outputs registered.
module latch_bank_ctrl #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 2,
    parameter int EN_CYCLES   = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    latch_bank_ctrl_if.slave bus
);
    localparam int N_LATCH = 1 << ADDR_W;
    localparam int MAX_CYC = (EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES;
    // Counter holds (phase length - 1) down to 0, so it never needs to reach MAX_CYC.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, ACK} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               owner_q, owner_n;   // 0: requester 0 owns the bank
    logic               rr_q, rr_n;         // requester favoured on a tie
    logic               win;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [WIDTH-1:0]   lat_d_q, lat_d_n;   // doubles as the private data copy
    logic [N_LATCH-1:0] lat_en_q, lat_en_n;
    logic               gnt0_q, gnt0_n, gnt1_q, gnt1_n;
    logic               ack0_q, ack0_n, ack1_q, ack1_n;
    logic               busy_q, busy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            addr_q   <= '0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            owner_q  <= owner_n;
            rr_q     <= rr_n;
            addr_q   <= addr_n;
            lat_d_q  <= lat_d_n;
            lat_en_q <= lat_en_n;
            gnt0_q   <= gnt0_n;
            gnt1_q   <= gnt1_n;
            ack0_q   <= ack0_n;
            ack1_q   <= ack1_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        owner_n  = owner_q;
        rr_n     = rr_q;
        win      = 1'b0;
        addr_n   = addr_q;
        lat_d_n  = lat_d_q;
        lat_en_n = lat_en_q;
        gnt0_n   = gnt0_q;
        gnt1_n   = gnt1_q;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        busy_n   = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Lone requester wins outright; a tie goes to the rr pointer.
                    win      = (bus.req0 && bus.req1) ? rr_q : bus.req1;
                    owner_n  = win;
                    addr_n   = win ? bus.addr1 : bus.addr0;
                    lat_d_n  = win ? bus.data1 : bus.data0;
                    gnt0_n   = ~win;
                    gnt1_n   = win;
                    busy_n   = 1'b1;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                lat_en_n = N_LATCH'(1) << addr_q;
                cnt_n    = CNT_W'(EN_CYCLES - 1);
                state_n  = ENABLE;
            end
            ENABLE: begin
                if (cnt_q == '0) begin
                    lat_en_n = '0;
                    cnt_n    = CNT_W'(HOLD_CYCLES - 1);
                    state_n  = HOLD;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    ack0_n  = ~owner_q;
                    ack1_n  = owner_q;
                    state_n = ACK;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
                busy_n  = 1'b0;
                rr_n    = ~owner_q;
                state_n = IDLE;
            end
            default: begin
                lat_en_n = '0;
                gnt0_n   = 1'b0;
                gnt1_n   = 1'b0;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.lat_en = lat_en_q;
    assign bus.lat_d  = lat_d_q;
    assign bus.busy   = busy_q;
endmodule
